interval_timer: RTL and testbench
=================================

# interval_timer

Programmable 32-bit interval timer that sits between the processor-side register bus and the interrupt logic. It drives its own loadable up/down counter and consumes the terminal-count condition, which occurs at zero when counting down and at all-ones when counting up. On terminal count it reloads, or stops in one-shot mode, and raises a latched, acknowledgeable interrupt. Software programs it through four word registers.

## Interface
- WIDTH, 32, counter/register width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- we  in  1  register write strobe, sampled at posedge clk
- addr  in  2  register select: 0 RELOAD, 1 CTRL, 2 COUNT, 3 STATUS
- wdata  in  WIDTH  write data
- rdata  out  WIDTH  combinational read of register selected by addr
- irq  out  1  level interrupt = STATUS.pending & CTRL.ie
- tc_pulse  out  1  registered one-cycle strobe per terminal-count event

## Operation
- Registers:
  - RELOAD (rw): reload value.
  - CTRL (rw), bits [3:0]:
    - bit0 en
    - bit1 periodic (0 = one-shot)
    - bit2 dir (1 = up, 0 = down)
    - bit3 ie
    - upper bits read 0.
  - COUNT (rw): live counter.
  - STATUS: bit0 pending; write 1 clears it, write 0 has no effect; upper bits read 0.
- FSM states:
  - IDLE: counter holds.
  - RUN: counter steps by 1 each cycle, +1 if dir else -1, modulo 2^WIDTH.
  - DONE: one-shot expired; counter holds terminal value.
- Transitions:
  - IDLE/DONE -> RUN: CTRL write with wdata[0]=1; COUNT <= RELOAD on that edge.
  - RUN -> IDLE: CTRL write with wdata[0]=0; COUNT holds current value.
  - RUN with CTRL write wdata[0]=1: stays RUN without reload; only periodic/dir/ie are updated.
  - RUN -> DONE: terminal count with periodic=0; CTRL.en is cleared by hardware on the same edge.
- Terminal count: in RUN, COUNT==0 with dir=0, or COUNT=={WIDTH{1}} with dir=1. On that edge:
  - pending <= 1
  - tc_pulse <= 1 for exactly one cycle
  - periodic=1: COUNT <= RELOAD, stay RUN
  - periodic=0: COUNT unchanged, go DONE
- Period in periodic mode:
  - down: RELOAD+1 cycles
  - up: 2^WIDTH - RELOAD cycles
- RELOAD=0 with dir=0 and periodic: terminal every cycle, so tc_pulse stays high continuously.
- Priorities:
  - COUNT write in RUN beats the step and suppresses terminal detection that cycle; counting resumes from the written value next cycle.
  - COUNT write in IDLE/DONE just loads; state is unchanged.
  - STATUS clear and terminal event on the same edge: set wins, pending stays 1.
  - RELOAD write in RUN affects only the next reload.
  - CTRL.dir change in RUN takes effect from the next step; terminal detection uses the current dir.
- Reset (asynchronous, rst_n=0), mid-operation included:
  - RELOAD=0, CTRL=0, COUNT=0, pending=0, state IDLE.
  - tc_pulse=0, irq=0.
  - rdata reflects the reset registers.

## Timing
- All state updates on posedge clk; rst_n asserts asynchronously, deasserts synchronously to clk (released by the upstream reset synchronizer).
- Write-to-effect latency: 1 edge. A register written at edge N reads back its new value after edge N.
- Read path is combinational from addr: zero latency, no read side effects.
- Enable latency: CTRL write at edge N loads RELOAD at N; first step occurs at N+1.
- Terminal to outputs:
  - Terminal value present before edge T; tc_pulse and pending are high after T.
  - irq is high after T when ie=1, with no extra register stage.
- STATUS clear: irq falls after the clearing edge, unless a new terminal event lands on the same edge.

## Test plan
- Reset: drive rst_n=0 mid-RUN with COUNT=0x1234 -> all registers read 0, irq=0, tc_pulse=0 immediately and without a clock edge.
- Periodic down: RELOAD=4, CTRL=0xB (en, periodic, ie) -> tc_pulse every 5 cycles. COUNT sequence 4,3,2,1,0,4…; irq high from the first terminal until a STATUS write of 1.
- One-shot up: RELOAD=0xFFFFFFFD, CTRL=0x5 -> terminal after 3 steps, then state DONE, COUNT=0xFFFFFFFF, CTRL reads 0x4, one tc_pulse only.
- Simultaneous clear and terminal: schedule a STATUS write of 1 on the terminal edge -> pending remains 1, irq stays high.
- COUNT write in RUN: RUN down from RELOAD=100; write COUNT=0 while COUNT=50 -> no terminal that edge, next edge COUNT=0, terminal on the following edge, then reload to 100.
- Disable/re-enable: CTRL=0 while COUNT=7 -> COUNT holds 7 in IDLE. CTRL=0x1 -> COUNT reloads to RELOAD, not 7.

Source files
------------

// File: rtl/interval_timer.sv
// Programmable up/down interval timer with reload, one-shot/periodic modes and a
// latched interrupt, controlled through four word registers.
module interval_timer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             irq,
   output logic             tc_pulse
);

   localparam logic [1:0] A_RELOAD = 2'd0;
   localparam logic [1:0] A_CTRL   = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic             pending_q, pending_d;
   logic             tc_q, tc_d;

   logic reload_wr, ctrl_wr, count_wr, status_wr;
   logic stop_wr, step_en, terminal;
   logic periodic, dir_up;

   assign reload_wr = we && (addr == A_RELOAD);
   assign ctrl_wr   = we && (addr == A_CTRL);
   assign count_wr  = we && (addr == A_COUNT);
   assign status_wr = we && (addr == A_STATUS);
   assign periodic  = ctrl_q[1];
   assign dir_up    = ctrl_q[2];
   assign stop_wr   = ctrl_wr && !wdata[0];

   // A COUNT write or a disable in RUN suppresses both the step and terminal detection.
   assign step_en  = (state_q == S_RUN) && !count_wr && !stop_wr;
   assign terminal = step_en && (dir_up ? (&count_q) : (count_q == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         reload_q  <= '0;
         count_q   <= '0;
         ctrl_q    <= '0;
         pending_q <= 1'b0;
         tc_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         reload_q  <= reload_d;
         count_q   <= count_d;
         ctrl_q    <= ctrl_d;
         pending_q <= pending_d;
         tc_q      <= tc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (ctrl_wr && wdata[0]) state_d = S_RUN;
         S_RUN: begin
            if (stop_wr)                   state_d = S_IDLE;
            else if (terminal && !periodic) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      reload_d  = reload_wr ? wdata : reload_q;
      ctrl_d    = ctrl_wr ? wdata[3:0] : ctrl_q;
      count_d   = count_q;
      pending_d = pending_q;
      tc_d      = terminal;

      // One-shot expiry clears en in hardware, overriding any same-edge CTRL write.
      if (terminal && !periodic) ctrl_d[0] = 1'b0;

      if (count_wr) begin
         count_d = wdata;
      end else if (ctrl_wr && wdata[0] && (state_q != S_RUN)) begin
         count_d = reload_q;
      end else if (terminal) begin
         count_d = periodic ? reload_q : count_q;
      end else if (step_en) begin
         count_d = dir_up ? count_q + 1'b1 : count_q - 1'b1;
      end

      // A terminal event on the clearing edge keeps pending set.
      if (terminal)                   pending_d = 1'b1;
      else if (status_wr && wdata[0]) pending_d = 1'b0;
   end

   always_comb begin
      case (addr)
         A_RELOAD: rdata = reload_q;
         A_CTRL:   rdata = {{(WIDTH-4){1'b0}}, ctrl_q};
         A_COUNT:  rdata = count_q;
         default:  rdata = {{(WIDTH-1){1'b0}}, pending_q};
      endcase
   end

   assign irq      = pending_q && ctrl_q[3];
   assign tc_pulse = tc_q;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed register programming with a
// scoreboard of expected per-cycle COUNT / tc_pulse / irq values.
module tb_interval_timer;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;
   logic        tc_pulse;

   int checks;
   int failures;

   typedef struct {
      logic [31:0] cnt;
      logic        tc;
      logic        irq;
   } exp_t;

   exp_t sb_q[$];

   interval_timer #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .irq      (irq),
      .tc_pulse (tc_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
      $display("WR addr=%0d data=%h", a, d);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input logic [31:0] c, input logic t, input logic i);
      exp_t e;
      e.cnt = c;
      e.tc  = t;
      e.irq = i;
      sb_q.push_back(e);
   endtask

   // Compare the current cycle against the queue head, then advance one edge per entry.
   task automatic run_sb();
      exp_t        e;
      logic [31:0] v;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         rd(2'd2, v);
         check_val("sb_count", v, e.cnt);
         check_val("sb_tc", {31'b0, tc_pulse}, {31'b0, e.tc});
         check_val("sb_irq", {31'b0, irq}, {31'b0, e.irq});
         if (sb_q.size() > 0) tick(1);
      end
   endtask

   task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] v;
      rd(a, v);
      check_val(tag, v, exp);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      we       = 1'b0;
      addr     = 2'd0;
      wdata    = '0;
      rst_n    = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_reg("rst0_reload", 2'd0, 32'h0);
      check_reg("rst0_ctrl", 2'd1, 32'h0);
      check_reg("rst0_count", 2'd2, 32'h0);
      check_reg("rst0_status", 2'd3, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Periodic down, RELOAD=4: terminal every 5 cycles, irq latched.
      wr(2'd0, 32'd4);
      push_exp(4, 0, 0); push_exp(3, 0, 0); push_exp(2, 0, 0); push_exp(1, 0, 0);
      push_exp(0, 0, 0); push_exp(4, 1, 1); push_exp(3, 0, 1); push_exp(2, 0, 1);
      push_exp(1, 0, 1); push_exp(0, 0, 1); push_exp(4, 1, 1);
      wr(2'd1, 32'hB);
      run_sb();

      wr(2'd3, 32'h1);
      check_reg("clr_count", 2'd2, 32'd3);
      check_reg("clr_status", 2'd3, 32'd0);
      check_val("clr_irq", {31'b0, irq}, 32'd0);

      // Clear on the terminal edge: set wins.
      tick(3);
      wr(2'd3, 32'h1);
      check_reg("simul_count", 2'd2, 32'd4);
      check_reg("simul_status", 2'd3, 32'd1);
      check_val("simul_irq", {31'b0, irq}, 32'd1);
      check_val("simul_tc", {31'b0, tc_pulse}, 32'd1);

      wr(2'd3, 32'h0);
      check_reg("w0_status", 2'd3, 32'd1);

      wr(2'd1, 32'h0);
      check_reg("dis_count", 2'd2, 32'd3);
      check_val("dis_irq", {31'b0, irq}, 32'd0);
      wr(2'd3, 32'h1);
      check_reg("dis_status", 2'd3, 32'd0);

      // Disable at 7, re-enable reloads from RELOAD.
      wr(2'd0, 32'd20);
      wr(2'd1, 32'h1);
      check_reg("en_count", 2'd2, 32'd20);
      tick(13);
      check_reg("pre7_count", 2'd2, 32'd7);
      wr(2'd1, 32'h0);
      tick(2);
      check_reg("hold7_count", 2'd2, 32'd7);
      wr(2'd1, 32'h1);
      check_reg("reen_count", 2'd2, 32'd20);
      check_reg("reen_ctrl", 2'd1, 32'h1);
      wr(2'd1, 32'h0);

      // One-shot up from 0xFFFFFFFD.
      wr(2'd0, 32'hFFFF_FFFD);
      push_exp(32'hFFFF_FFFD, 0, 0); push_exp(32'hFFFF_FFFE, 0, 0);
      push_exp(32'hFFFF_FFFF, 0, 0); push_exp(32'hFFFF_FFFF, 1, 0);
      push_exp(32'hFFFF_FFFF, 0, 0); push_exp(32'hFFFF_FFFF, 0, 0);
      wr(2'd1, 32'h5);
      run_sb();
      check_reg("os_ctrl", 2'd1, 32'h4);
      check_reg("os_status", 2'd3, 32'h1);
      wr(2'd3, 32'h1);

      // COUNT write in RUN.
      wr(2'd0, 32'd100);
      wr(2'd1, 32'h3);
      tick(50);
      check_reg("cw_pre_count", 2'd2, 32'd50);
      push_exp(0, 0, 0); push_exp(100, 1, 0); push_exp(99, 0, 0);
      wr(2'd2, 32'd0);
      run_sb();

      // RELOAD=0 periodic down: tc_pulse held high.
      wr(2'd1, 32'h0);
      wr(2'd0, 32'd0);
      push_exp(0, 0, 0); push_exp(0, 1, 0); push_exp(0, 1, 0); push_exp(0, 1, 0);
      wr(2'd1, 32'h3);
      run_sb();
      wr(2'd1, 32'h0);

      // Asynchronous reset mid-RUN with irq asserted.
      wr(2'd0, 32'h5555);
      wr(2'd1, 32'hB);
      wr(2'd2, 32'h1234);
      check_reg("pre_rst_count", 2'd2, 32'h1234);
      check_val("pre_rst_irq", {31'b0, irq}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_reg("rst_reload", 2'd0, 32'h0);
      check_reg("rst_ctrl", 2'd1, 32'h0);
      check_reg("rst_count", 2'd2, 32'h0);
      check_reg("rst_status", 2'd3, 32'h0);
      check_val("rst_irq", {31'b0, irq}, 32'd0);
      check_val("rst_tc", {31'b0, tc_pulse}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick(2);
      check_reg("post_rst_count", 2'd2, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
